// File: rtl/ram_if_bram_device_pkg.sv
// RAM: shared RAM_IF size codes, device FSM states and byte-lane helpers.
// Latency: none, only types and pure functions.
// Backpressure: not applicable.
package RAM;

    // DIN_SIZE codes carried on the bus; 2'b11 is treated as a full word
    localparam logic [1:0] DIN_SIZE_8  = 2'b00;
    localparam logic [1:0] DIN_SIZE_16 = 2'b01;
    localparam logic [1:0] DIN_SIZE_32 = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        LOAD,
        ACK,
        CLEAR
    } RAM_DEV_STATE_t;

    typedef enum logic [1:0] {
        CMD_NONE,
        CMD_READ,
        CMD_WRITE,
        CMD_RFSH
    } RAM_DEV_CMD_t;

    // Lanes touched by a write of the given size at the given byte offset
    function automatic logic [3:0] byte_enable(input logic [1:0] din_size,
                                               input logic [1:0] addr_lsb);
        logic [3:0] be;
        case (din_size)
            DIN_SIZE_8:  be = 4'b0001 << addr_lsb;
            DIN_SIZE_16: be = addr_lsb[1] ? 4'b1100 : 4'b0011;
            default:     be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate right-aligned write data across lanes so byte enables pick the right copy
    function automatic logic [31:0] write_lanes(input logic [31:0] din,
                                                input logic [1:0]  din_size);
        logic [31:0] w;
        case (din_size)
            DIN_SIZE_8:  w = {4{din[7:0]}};
            DIN_SIZE_16: w = {2{din[15:0]}};
            default:     w = din;
        endcase
        return w;
    endfunction

    // Rotate a word right by whole bytes so the addressed byte lands in [7:0]
    function automatic logic [31:0] rotate_right_bytes(input logic [31:0] word,
                                                       input logic [1:0]  sh);
        logic [31:0] r;
        case (sh)
            2'd0:    r = word;
            2'd1:    r = {word[7:0],  word[31:8]};
            2'd2:    r = {word[15:0], word[31:16]};
            default: r = {word[23:0], word[31:24]};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ram_if.sv
// RAM_IF: host/device bus bundle for the RAM tree.
// Latency: none, wiring only.
// Backpressure: device holds ACK_n low until host releases all requests.
interface RAM_IF #(
    parameter int ADDR_BIT_WIDTH = 24
);
    logic [ADDR_BIT_WIDTH-1:0] ADDR;
    logic                      OE_n;
    logic                      WE_n;
    logic                      RFSH_n;
    logic [31:0]               DIN;
    logic [1:0]                DIN_SIZE;
    logic [31:0]               DOUT;
    logic                      ACK_n;
    logic                      TIMING;

    modport DEVICE (
        input  ADDR, OE_n, WE_n, RFSH_n, DIN, DIN_SIZE,
        output DOUT, ACK_n, TIMING
    );

    modport HOST (
        output ADDR, OE_n, WE_n, RFSH_n, DIN, DIN_SIZE,
        input  DOUT, ACK_n, TIMING
    );
endinterface

// File: rtl/ram_if_bram_device_core.sv
// ram_bram_core: single-port 2^ADDR_BITS x 32 RAM with per-byte write enables.
// Latency: write lands on the edge, read data registered one clock after rd_en.
// Backpressure: none, accepts one access every clock.
module ram_bram_core #(
    parameter int ADDR_BITS = 12
) (
    input  logic                 CLK,
    input  logic                 rd_en,
    input  logic [3:0]           we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [31:0] mem [0:DEPTH-1];

    // Byte-lane writes and registered read share the single port
    always_ff @(posedge CLK) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (rd_en) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/ram_if_bram_device.sv
// ram_if_bram_device: RAM_IF responder backed by on-chip RAM, plus TIMING strobe generator.
// Latency: accept edge to ACK_n low is 2 clocks; first TIMING TIMING_PERIOD clocks after reset.
// Backpressure: accepts only on TIMING in IDLE; ACK_n held low until all requests release.
// Option RAM_BRAM_ZERO_CLEAR_EN: zero every word after reset before accepting requests.
module ram_if_bram_device
    import RAM::*;
#(
    parameter int ADDR_BIT_WIDTH = 24,
    parameter int MEM_ADDR_BITS  = 12,
    parameter int TIMING_PERIOD  = 4
) (
    input  logic   CLK,
    input  logic   RESET_n,
    RAM_IF.DEVICE  Bus
);

    localparam int CNT_W = $clog2(TIMING_PERIOD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMING_PERIOD - 1);

    RAM_DEV_STATE_t             state_q;
    RAM_DEV_CMD_t               cmd_q;
    logic [MEM_ADDR_BITS+1:0]   addr_q;
    logic [31:0]                din_q;
    logic [1:0]                 size_q;
    logic [31:0]                dout_q;
    logic                       ack_n_q;
    logic                       timing_q;
    logic [CNT_W-1:0]           tmr_cnt;

    logic                       ram_rd_en;
    logic [3:0]                 ram_we;
    logic [MEM_ADDR_BITS-1:0]   ram_addr;
    logic [31:0]                ram_wdata;
    logic [31:0]                ram_rdata;

    logic                       req_any;
    logic                       unused_addr_hi;

`ifdef RAM_BRAM_ZERO_CLEAR_EN
    logic [MEM_ADDR_BITS-1:0]   clr_addr;
    localparam logic [MEM_ADDR_BITS-1:0] CLR_LAST = '1;
`endif

    assign req_any = ~Bus.OE_n | ~Bus.WE_n | ~Bus.RFSH_n;

    // Upper address bits alias onto the RAM and are deliberately dropped
    assign unused_addr_hi = ^Bus.ADDR[ADDR_BIT_WIDTH-1:MEM_ADDR_BITS+2];

    assign Bus.DOUT   = dout_q;
    assign Bus.ACK_n  = ack_n_q;
    assign Bus.TIMING = timing_q;

    // Free-running period counter; strobe registered on the last count
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            tmr_cnt  <= '0;
            timing_q <= 1'b0;
        end else begin
            tmr_cnt  <= (tmr_cnt == CNT_LAST) ? '0 : tmr_cnt + 1'b1;
            timing_q <= (tmr_cnt == CNT_LAST);
        end
    end

    // RAM port steering: latched access in ACCESS, zero sweep in CLEAR
    always_comb begin
        ram_rd_en = 1'b0;
        ram_we    = 4'b0000;
        ram_addr  = addr_q[MEM_ADDR_BITS+1:2];
        ram_wdata = write_lanes(din_q, size_q);
        if (state_q == ACCESS) begin
            if (cmd_q == CMD_WRITE) begin
                ram_we = byte_enable(size_q, addr_q[1:0]);
            end else if (cmd_q == CMD_READ) begin
                ram_rd_en = 1'b1;
            end
        end
`ifdef RAM_BRAM_ZERO_CLEAR_EN
        if (state_q == CLEAR) begin
            ram_addr  = clr_addr;
            ram_we    = 4'b1111;
            ram_wdata = '0;
        end
`endif
    end

    // Access sequencer: IDLE -> ACCESS -> LOAD -> ACK -> IDLE
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
`ifdef RAM_BRAM_ZERO_CLEAR_EN
            state_q  <= CLEAR;
            clr_addr <= '0;
`else
            state_q  <= IDLE;
`endif
            cmd_q    <= CMD_NONE;
            addr_q   <= '0;
            din_q    <= '0;
            size_q   <= DIN_SIZE_32;
            dout_q   <= '0;
            ack_n_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (timing_q && req_any) begin
                        addr_q <= Bus.ADDR[MEM_ADDR_BITS+1:0];
                        din_q  <= Bus.DIN;
                        size_q <= Bus.DIN_SIZE;
                        // Write wins over read, read over refresh
                        if (!Bus.WE_n) begin
                            cmd_q <= CMD_WRITE;
                        end else if (!Bus.OE_n) begin
                            cmd_q <= CMD_READ;
                        end else begin
                            cmd_q <= CMD_RFSH;
                        end
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    state_q <= LOAD;
                end
                LOAD: begin
                    if (cmd_q == CMD_READ) begin
                        dout_q <= rotate_right_bytes(ram_rdata, addr_q[1:0]);
                    end
                    ack_n_q <= 1'b0;
                    state_q <= ACK;
                end
                ACK: begin
                    if (Bus.OE_n && Bus.WE_n && Bus.RFSH_n) begin
                        ack_n_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
`ifdef RAM_BRAM_ZERO_CLEAR_EN
                CLEAR: begin
                    clr_addr <= clr_addr + 1'b1;
                    if (clr_addr == CLR_LAST) begin
                        state_q <= IDLE;
                    end
                end
`endif
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    ram_bram_core #(
        .ADDR_BITS (MEM_ADDR_BITS)
    ) u_core (
        .CLK   (CLK),
        .rd_en (ram_rd_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_ram_if_bram_device.sv
// tb_ram_if_bram_device: directed vectors against ram_if_bram_device.
// Latency: checks ACK_n timing cycle by cycle.
// Backpressure: holds requests past ACK to exercise the release handshake.
module tb_ram_if_bram_device;
    import RAM::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    RAM_IF #(.ADDR_BIT_WIDTH(24)) bus ();

    ram_if_bram_device #(
        .ADDR_BIT_WIDTH (24),
        .MEM_ADDR_BITS  (12),
        .TIMING_PERIOD  (4)
    ) dut (
        .CLK     (clk),
        .RESET_n (rst_n),
        .Bus     (bus.DEVICE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%08h want 0x%08h", tag, act, exp);
        end
    endtask

    // Step to the next negedge on which TIMING is high, bounded
    task automatic wait_timing(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (bus.TIMING === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk({tag, "_timing_wait"}, 32'd0, 32'd1);
    endtask

    // One full host access; scrambles ADDR/DIN after accept, holds requests `hold` clocks past ACK
    task automatic access(input string tag, input logic we_n, input logic oe_n, input logic rf_n,
                          input logic [23:0] a, input logic [31:0] d, input logic [1:0] sz,
                          input int hold, input logic [31:0] exp_dout);
        int low_cnt;
        wait_timing(tag);
        bus.ADDR = a; bus.DIN = d; bus.DIN_SIZE = sz;
        bus.WE_n = we_n; bus.OE_n = oe_n; bus.RFSH_n = rf_n;
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_ack_c1"}, {31'd0, bus.ACK_n}, 32'd1);
        bus.ADDR = 24'hFFFFFF; bus.DIN = 32'hFFFFFFFF; bus.DIN_SIZE = DIN_SIZE_8;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_ack_c2"}, {31'd0, bus.ACK_n}, 32'd0);
        chk({tag, "_dout"}, bus.DOUT, exp_dout);
        low_cnt = 0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.ACK_n === 1'b0) low_cnt++;
        end
        if (hold > 0) chk({tag, "_ack_held"}, low_cnt, hold);
        bus.WE_n = 1'b1; bus.OE_n = 1'b1; bus.RFSH_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_ack_rel"}, {31'd0, bus.ACK_n}, 32'd1);
        chk({tag, "_dout_hold"}, bus.DOUT, exp_dout);
    endtask

    initial begin
        int bad;
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        bus.ADDR = '0; bus.DIN = '0; bus.DIN_SIZE = DIN_SIZE_32;
        bus.OE_n = 1'b1; bus.WE_n = 1'b1; bus.RFSH_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ack", {31'd0, bus.ACK_n}, 32'd1);
        chk("rst_dout", bus.DOUT, 32'd0);
        chk("rst_timing", {31'd0, bus.TIMING}, 32'd0);
        rst_n = 1'b1;

        // TIMING high after clocks 4, 8, 12 following release; idle outputs quiet
        bad = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.TIMING !== ((k % 4) == 0)) bad++;
            if (bus.ACK_n !== 1'b1 || bus.DOUT !== 32'd0) bad++;
        end
        chk("timing_idle", bad, 0);

`ifdef RAM_BRAM_ZERO_CLEAR_EN
        // Requests during the sweep must not be accepted
        bus.OE_n = 1'b0;
        bad = 0;
        for (int k = 0; k < 4080; k++) begin
            @(negedge clk);
            if (bus.ACK_n !== 1'b1) bad++;
        end
        bus.OE_n = 1'b1;
        chk("clear_no_accept", bad, 0);
        repeat (20) @(negedge clk);
        access("clear_rd0", 1'b1, 1'b0, 1'b1, 24'h000010, 32'h0, DIN_SIZE_32, 0, 32'h00000000);
`endif

        access("wr32",  1'b0, 1'b1, 1'b1, 24'h000010, 32'h12345678, DIN_SIZE_32, 0, 32'h00000000);
        access("rd32",  1'b1, 1'b0, 1'b1, 24'h000010, 32'h0,        DIN_SIZE_32, 0, 32'h12345678);
        // Byte 0xAB into lane 2: word 0x12AB5678, read at offset 2 rotates right by 16
        access("wr8",   1'b0, 1'b1, 1'b1, 24'h000012, 32'h000000AB, DIN_SIZE_8,  0, 32'h12345678);
        access("rd8",   1'b1, 1'b0, 1'b1, 24'h000012, 32'h0,        DIN_SIZE_32, 0, 32'h567812AB);
        // Halfword at 0x13 ignores ADDR[0]: lanes 3:2 -> 0xBEEF5678
        access("wr16",  1'b0, 1'b1, 1'b1, 24'h000013, 32'h0000BEEF, DIN_SIZE_16, 0, 32'h567812AB);
        access("rd16",  1'b1, 1'b0, 1'b1, 24'h000010, 32'h0,        DIN_SIZE_32, 0, 32'hBEEF5678);
        // Alias: bit 14 lies above the RAM index and wraps back to word 4
        access("rd_alias", 1'b1, 1'b0, 1'b1, 24'h004011, 32'h0,     DIN_SIZE_32, 0, 32'h78BEEF56);
        // Write+read together: write only, DOUT unchanged, ACK held 10 clocks
        access("wr_rd", 1'b0, 1'b0, 1'b1, 24'h000010, 32'h00000000, DIN_SIZE_32, 10, 32'h78BEEF56);
        access("rd_zero", 1'b1, 1'b0, 1'b1, 24'h000010, 32'h0,      DIN_SIZE_32, 0, 32'h00000000);
        access("rfsh",  1'b1, 1'b1, 1'b0, 24'h000010, 32'h0,        DIN_SIZE_32, 2, 32'h00000000);
        access("wr_cafe", 1'b0, 1'b1, 1'b1, 24'h000010, 32'hCAFEF00D, DIN_SIZE_32, 0, 32'h00000000);

        // Reset pulsed while in ACK: outputs return to reset values at once
        wait_timing("rst_ack");
        bus.ADDR = 24'h000010; bus.OE_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("mid_ack_low", {31'd0, bus.ACK_n}, 32'd0);
        chk("mid_dout", bus.DOUT, 32'hCAFEF00D);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ack", {31'd0, bus.ACK_n}, 32'd1);
        chk("mid_rst_dout", bus.DOUT, 32'd0);
        bus.OE_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
`ifdef RAM_BRAM_ZERO_CLEAR_EN
        repeat (4110) @(negedge clk);
        access("post_rst_rd", 1'b1, 1'b0, 1'b1, 24'h000010, 32'h0, DIN_SIZE_32, 0, 32'h00000000);
`else
        repeat (5) @(negedge clk);
        access("post_rst_rd", 1'b1, 1'b0, 1'b1, 24'h000010, 32'h0, DIN_SIZE_32, 0, 32'hCAFEF00D);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
